int_ctrl: RTL and testbench
===========================

Name: int_ctrl

Overview:
- Memory-mapped interrupt controller on the CPU peripheral bus.
- Samples up to NSRC device interrupt sources and captures each one as edge- or level-triggered.
- Masks and prioritises the pending sources, then drives one registered request line into a CPU hwint input (hwint2 by integration).
- Software configures it, identifies the active source and acknowledges it through four word registers.

Parameters:
NSRC, 8, number of interrupt sources (1..32); source 0 is highest priority.

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
sel  input  1  bridge chip select for this device
addr  input  2  word offset (bus address bits [3:2])
we  input  1  write strobe, effective only with sel
be  input  4  byte enables for the write
wd  input  32  write data
rd  output  32  read data (combinational on addr)
src  input  NSRC  raw interrupt sources, synchronous to clk
irq  output  1  registered interrupt request to the CPU

Behaviour:
Interface:
- One clock; reset is synchronous and active-high, sampled on the rising edge of clk.
- The ports are named clk and reset.

Reset:
- pend, mask, mode, src_prev and irq are all 0.
- rd then reads 0 at every offset, including ACTIVE (valid=0).

Register map (addr):
- 0 PEND: read gives pend zero-extended to 32 bits. A write is write-1-to-clear and affects edge sources only; writes to level bits are ignored.
- 1 MASK: RW enable per source. Only bytes with be set are written. Bits at or above NSRC read 0.
- 2 MODE: RW per source, 1 = edge, 0 = level. Byte-enabled like MASK.
- 3 ACTIVE: read gives {valid, 26'b0, idx[4:0]}. idx is the lowest index i with pend[i] & mask[i]; valid=0 and idx=0 if there is none. A write with be[0]=1 acknowledges source wd[4:0]. The ack clears pend for that source only if it is edge mode and wd[4:0] < NSRC; otherwise the write is ignored.

Source capture (every cycle):
- src_prev <= src.
- rise = src & ~src_prev.
- Edge bit: pend <= (pend & ~clr) | rise. Set has priority over a same-cycle clear (W1C or ACK).
- Level bit: pend <= src. It tracks the source and is unaffected by clears.
- Mode change edge->level: pend follows src from the next edge.
- Mode change level->edge: the current pend value is kept until cleared.

Output:
- irq <= |(pend & mask) on every edge.
- Latency: src rises before edge k -> pend set at edge k -> irq high after edge k+1.
- A clear or mask write at edge k drops irq after edge k+1.

Other rules:
- Reads have no side effects; rd depends only on addr and current state, regardless of sel.
- Writes with sel=0 or we=0 have no effect.
- A write with be=0 has no effect.
- Offsets 1 and 2 are never written together, because there is one write per cycle.
- Reset asserted mid-operation clears all state on that edge, overriding any same-cycle write or source edge.
- src high through the reset release must not generate an edge: src_prev reset to 0 would otherwise produce rise, so after reset src_prev is loaded from src and rise is suppressed on the first post-reset edge.

Test Plan:
- Reset value check: hold reset 2 cycles with src=8'hFF, then release. Require rd=0 at offsets 0..3, irq=0, and no edge pend on the first cycle after release with mode=8'hFF written.
- Edge capture and ack: write MODE=8'h08 and MASK=8'h08, then pulse src[3] for 1 cycle. Require PEND=8'h08 and irq=1 two edges after the pulse, and ACTIVE=32'h8000_0003. Write ACTIVE wd=3; require PEND=0 and irq=0 one edge later.
- Level tracking: MODE=0, MASK=8'h01. Hold src[0]=1 for 5 cycles; require irq=1 throughout, starting 2 edges after assertion. Write PEND=8'h01 and require no change. Drop src[0]; require irq=0 two edges later.
- Priority and mask: make src[5] and src[2] pending (edge), MASK=8'h24. Require ACTIVE idx=2. Clear MASK bit 2; require idx=5. Write MASK=0; require valid=0 and irq=0.
- Simultaneous set and clear: in the same cycle, src[1] rises and W1C PEND=8'h02 is written. Require pend[1]=1 afterwards.
- Byte enable and bounds: with NSRC=8, write MASK=32'hFFFF_FFFF, be=4'b0010 -> MASK reads 0. Write be=4'b0001 -> MASK reads 8'hFF. Write ACTIVE wd=9 -> no state change.

Source files
------------

// File: rtl/int_ctrl.sv
// Memory-mapped interrupt controller: captures edge/level sources, masks and
// prioritises them, and drives one registered request line to the CPU.
module int_ctrl #(
  parameter int NSRC = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sel,
  input  logic [1:0]      addr,
  input  logic            we,
  input  logic [3:0]      be,
  input  logic [31:0]     wd,
  output logic [31:0]     rd,
  input  logic [NSRC-1:0] src,
  output logic            irq
);

  localparam logic [1:0] A_PEND   = 2'd0;
  localparam logic [1:0] A_MASK   = 2'd1;
  localparam logic [1:0] A_MODE   = 2'd2;
  localparam logic [1:0] A_ACTIVE = 2'd3;

  logic [NSRC-1:0] pend, mask, mode, src_prev;
  logic            armed;

  logic            wr;
  logic [31:0]     bmask;
  logic [NSRC-1:0] bm, rise, clr, ack_vec, act, pend_next;
  logic            ack_ok, valid;
  logic [4:0]      idx;
  logic            unused_wd;

  assign wr        = sel & we;
  assign bmask     = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  assign bm        = bmask[NSRC-1:0];
  assign unused_wd = ^wd;

  // armed stays low for the first edge after reset so a source already high
  // at reset release is not mistaken for a rising edge.
  assign rise = src & ~src_prev & {NSRC{armed}};

  assign ack_ok  = wr && (addr == A_ACTIVE) && be[0] && (32'(wd[4:0]) < NSRC);
  assign ack_vec = NSRC'(1) << wd[4:0];

  assign clr = ((wr && addr == A_PEND) ? (wd[NSRC-1:0] & bm) : '0)
             | (ack_ok ? ack_vec : '0);

  // Edge bits: set wins over a same-cycle clear. Level bits follow src.
  assign pend_next = (mode & ((pend & ~clr) | rise)) | (~mode & src);

  assign act = pend & mask;

  // NOTE: every variable driven in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    valid = 1'b0;
    idx   = 5'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (act[i]) begin
        valid = 1'b1;
        idx   = 5'(i);
      end
    end
  end

  always_comb begin
    rd = 32'd0;
    case (addr)
      A_PEND:   rd = 32'(pend);
      A_MASK:   rd = 32'(mask);
      A_MODE:   rd = 32'(mode);
      A_ACTIVE: rd = {valid, 26'd0, idx};
      default:  rd = 32'd0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend     <= '0;
      mask     <= '0;
      mode     <= '0;
      src_prev <= '0;
      armed    <= 1'b0;
      irq      <= 1'b0;
    end else begin
      src_prev <= src;
      armed    <= 1'b1;
      pend     <= pend_next;
      irq      <= |act;
      if (wr && addr == A_MASK)
        mask <= (mask & ~bm) | (wd[NSRC-1:0] & bm);
      if (wr && addr == A_MODE)
        mode <= (mode & ~bm) | (wd[NSRC-1:0] & bm);
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl; expectations go into a scoreboard queue and a
// monitor compares them against rd/irq when a read is presented.
module tb_int_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic [1:0]  addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wd;
  logic [31:0] rd;
  logic [7:0]  src;
  logic        irq;

  int_ctrl #(.NSRC(8)) dut (
    .clk(clk), .reset(reset), .sel(sel), .addr(addr), .we(we), .be(be),
    .wd(wd), .rd(rd), .src(src), .irq(irq)
  );

  always #10 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  logic mon_req = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  // Monitor: each presented read is compared with the oldest expectation.
  always @(posedge mon_req) begin
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_read: rd=%h irq=%b with empty scoreboard", rd, irq);
    end else begin
      e = sb.pop_front();
      if (rd !== e.exp_rd || irq !== e.exp_irq) begin
        n_fail++;
        $display("FAIL %s: got rd=%h irq=%b, expected rd=%h irq=%b",
                 e.name, rd, irq, e.exp_rd, e.exp_irq);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] b);
    sel = 1'b1; we = 1'b1; addr = a; wd = d; be = b;
    tick();
    sel = 1'b0; we = 1'b0; be = 4'd0; wd = 32'd0;
  endtask

  // Presents a read without consuming a clock edge.
  task automatic check(input string name, input logic [1:0] a,
                       input logic [31:0] exp_rd, input logic exp_irq);
    exp_t x;
    addr = a;
    #1;
    x.name = name; x.exp_rd = exp_rd; x.exp_irq = exp_irq;
    sb.push_back(x);
    mon_req = 1'b1;
    #1;
    mon_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; sel = 1'b0; we = 1'b0; addr = 2'd0; be = 4'd0; wd = 32'd0;
    src = 8'hFF;

    // Reset state with sources held high
    tick(); tick();
    check("rst_pend",   2'd0, 32'd0, 1'b0);
    check("rst_mask",   2'd1, 32'd0, 1'b0);
    check("rst_mode",   2'd2, 32'd0, 1'b0);
    check("rst_active", 2'd3, 32'd0, 1'b0);
    reset = 1'b0;
    write(2'd2, 32'h0000_00FF, 4'b0001);
    check("rel_pend_level", 2'd0, 32'h0000_00FF, 1'b0);
    check("rel_mode",       2'd2, 32'h0000_00FF, 1'b0);
    write(2'd0, 32'h0000_00FF, 4'b0001);
    check("rel_w1c", 2'd0, 32'd0, 1'b0);
    tick();
    check("rel_no_edge",   2'd0, 32'd0, 1'b0);
    check("rel_no_active", 2'd3, 32'd0, 1'b0);
    src = 8'h00;
    tick();

    // Edge capture and acknowledge
    write(2'd2, 32'h0000_0008, 4'b0001);
    write(2'd1, 32'h0000_0008, 4'b0001);
    src = 8'h08;
    tick();
    src = 8'h00;
    check("edge_pend_set", 2'd0, 32'h0000_0008, 1'b0);
    tick();
    check("edge_irq",    2'd0, 32'h0000_0008, 1'b1);
    check("edge_active", 2'd3, 32'h8000_0003, 1'b1);
    write(2'd3, 32'd3, 4'b0001);
    check("ack_pend", 2'd0, 32'd0, 1'b1);
    tick();
    check("ack_irq_drop", 2'd3, 32'd0, 1'b0);

    // Level tracking
    write(2'd2, 32'd0, 4'b0001);
    write(2'd1, 32'h0000_0001, 4'b0001);
    src = 8'h01;
    tick();
    check("lvl_pend_first", 2'd0, 32'h0000_0001, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("lvl_hold%0d", i), 2'd0, 32'h0000_0001, 1'b1);
    end
    write(2'd0, 32'h0000_0001, 4'b0001);
    check("lvl_w1c_ignored", 2'd0, 32'h0000_0001, 1'b1);
    src = 8'h00;
    tick();
    check("lvl_drop_pend", 2'd0, 32'd0, 1'b1);
    tick();
    check("lvl_drop_irq", 2'd0, 32'd0, 1'b0);

    // Priority and masking
    write(2'd2, 32'h0000_00FF, 4'b0001);
    src = 8'h24;
    tick();
    src = 8'h00;
    write(2'd1, 32'h0000_0024, 4'b0001);
    check("prio_idx2", 2'd3, 32'h8000_0002, 1'b0);
    write(2'd1, 32'h0000_0020, 4'b0001);
    check("prio_idx5", 2'd3, 32'h8000_0005, 1'b1);
    write(2'd1, 32'h0000_0000, 4'b0001);
    check("prio_none", 2'd3, 32'd0, 1'b1);
    tick();
    check("prio_irq_drop", 2'd3, 32'd0, 1'b0);
    check("prio_pend_kept", 2'd0, 32'h0000_0024, 1'b0);
    write(2'd0, 32'h0000_00FF, 4'b0001);
    check("prio_cleared", 2'd0, 32'd0, 1'b0);

    // Same-cycle set and clear: set wins
    src = 8'h02;
    write(2'd0, 32'h0000_0002, 4'b1111);
    src = 8'h00;
    check("setclr_set_wins", 2'd0, 32'h0000_0002, 1'b0);
    write(2'd0, 32'h0000_0002, 4'b1111);
    check("setclr_w1c", 2'd0, 32'd0, 1'b0);

    // Byte enables and bounds
    write(2'd1, 32'hFFFF_FFFF, 4'b0010);
    check("be_upper_only", 2'd1, 32'd0, 1'b0);
    write(2'd1, 32'hFFFF_FFFF, 4'b0001);
    check("be_low_byte", 2'd1, 32'h0000_00FF, 1'b0);
    src = 8'h10;
    tick();
    src = 8'h00;
    write(2'd3, 32'd9, 4'b0001);
    check("ack_oob_pend",   2'd0, 32'h0000_0010, 1'b1);
    check("ack_oob_active", 2'd3, 32'h8000_0004, 1'b1);
    write(2'd3, 32'd4, 4'b0000);
    check("ack_be0", 2'd0, 32'h0000_0010, 1'b1);
    write(2'd3, 32'd4, 4'b0001);
    check("ack_src4", 2'd0, 32'd0, 1'b1);
    sel = 1'b0; we = 1'b1; addr = 2'd1; wd = 32'd0; be = 4'b1111;
    tick();
    we = 1'b0; be = 4'd0;
    check("nosel_write", 2'd1, 32'h0000_00FF, 1'b0);

    // Reset mid-operation overrides a write and a source edge
    src = 8'h01;
    tick();
    src = 8'h00;
    tick();
    check("pre_reset", 2'd0, 32'h0000_0001, 1'b1);
    reset = 1'b1; sel = 1'b1; we = 1'b1; addr = 2'd1; wd = 32'hFF; be = 4'b1111;
    src = 8'h80;
    tick();
    sel = 1'b0; we = 1'b0; be = 4'd0;
    check("mid_rst_pend",   2'd0, 32'd0, 1'b0);
    check("mid_rst_mask",   2'd1, 32'd0, 1'b0);
    check("mid_rst_mode",   2'd2, 32'd0, 1'b0);
    check("mid_rst_active", 2'd3, 32'd0, 1'b0);
    reset = 1'b0;
    src = 8'h00;
    tick();

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
